// File: rtl/wb_bram_slave.sv
`default_nettype none
// ============================================================================
// Module   : wb_bram_slave
// Purpose  : Wishbone classic slave fronting a single-write-enable block RAM;
//            byte-lane writes are done by read-modify-write.
// Revision : 1.0
// ============================================================================
module wb_bram_slave #(
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hFFFF_F000,
    parameter int          RAM_LAT     = 1,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_data_in,
    input  logic [31:0]       ram_data_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_MERGE = 3'd2,
        S_WR    = 3'd3,
        S_WAIT  = 3'd4,
        S_ACK   = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [3:0] RD_INIT   = 4'(RAM_LAT - 1);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] dat_q;
    logic [3:0]  sel_q;
    logic        we_q;

    logic        req;
    logic        bad;
    logic        partial;
    logic [31:0] merged;

    assign req     = wb_cyc_i & wb_stb_i;
    assign bad     = ((wb_adr_i & ADDR_MASK) != BASE_ADDR) || (wb_adr_i[1:0] != 2'b00);
    assign partial = (wb_sel_i != 4'h0) && (wb_sel_i != 4'hF);

    always_comb begin
        merged = ram_data_out;
        for (int n = 0; n < 4; n++) begin
            if (sel_q[n]) merged[8*n +: 8] = dat_q[8*n +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            dat_q       <= 32'd0;
            sel_q       <= 4'd0;
            we_q        <= 1'b0;
            wb_dat_o    <= 32'd0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_data_in <= 32'd0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            ram_we   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        ram_addr <= wb_adr_i[ADDR_W+1:2];
                        dat_q    <= wb_dat_i;
                        sel_q    <= wb_sel_i;
                        we_q     <= wb_we_i;
                        if (bad) begin
                            state    <= S_ERR;
                            wb_err_o <= 1'b1;
                        end else if (!wb_we_i || partial) begin
                            state <= S_RD;
                            cnt   <= RD_INIT;
                        end else if (wb_sel_i == 4'hF) begin
                            state       <= S_WR;
                            ram_we      <= 1'b1;
                            ram_data_in <= wb_dat_i;
                        end else if (WAIT_CYCLES == 0) begin
                            state    <= S_ACK;
                            wb_ack_o <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_RD: begin
                    if (!wb_cyc_i) begin
                        state <= S_IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (we_q) begin
                        // Partial write: fold the fetched word with the new lanes.
                        state       <= S_MERGE;
                        ram_we      <= 1'b1;
                        ram_data_in <= merged;
                    end else begin
                        wb_dat_o <= ram_data_out;
                        if (WAIT_CYCLES == 0) begin
                            state    <= S_ACK;
                            wb_ack_o <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_MERGE, S_WR: begin
                    // The write pulse lands on this edge even if the cycle aborts.
                    if (!wb_cyc_i) begin
                        state <= S_IDLE;
                    end else if (WAIT_CYCLES == 0) begin
                        state    <= S_ACK;
                        wb_ack_o <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (!wb_cyc_i) begin
                        state <= S_IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state    <= S_ACK;
                        wb_ack_o <= 1'b1;
                    end
                end
                S_ACK, S_ERR: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
